// File: rtl/ldpc_msg_feeder_pkg.sv
// Shared LDPC feeder parameters, state encoding and small helpers.
// Every file that needs the defaults imports this package.
package ldpc_msg_feeder_pkg;

  localparam int Z_DEF     = 5;
  localparam int CYCLE_DEF = 3;
  localparam int SW_DEF    = 3;
  localparam logic [CYCLE_DEF*SW_DEF-1:0] SHIFT_TABLE_DEF = {3'd2, 3'd1, 3'd0};

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_FEED  = 2'd1,
    ST_LAST  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Block index width; kept at least one bit for single-block codewords.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ldpc_msg_feeder_if.sv
// Message-in / accumulator-out bundle of the LDPC message feeder.
// The master side is the block producer plus the parity consumer.
interface ldpc_msg_feeder_if
  import ldpc_msg_feeder_pkg::*;
#(
  parameter int Z  = Z_DEF,
  parameter int IW = idx_width(CYCLE_DEF)
);
  logic [Z-1:0]  in_data;
  logic          in_valid;
  logic          in_ready;
  logic [Z-1:0]  u;
  logic          ce;
  logic          acc_clr;
  logic [IW-1:0] blk_idx;
  logic          cw_done;
  logic          done_ack;

  modport master (
    output in_data, in_valid, done_ack,
    input  in_ready, u, ce, acc_clr, blk_idx, cw_done
  );

  modport slave (
    input  in_data, in_valid, done_ack,
    output in_ready, u, ce, acc_clr, blk_idx, cw_done
  );
endinterface

// File: rtl/ldpc_circ_rotate.sv
// Circulant rotation: rotated[(i+s) mod Z] = data[i], s = shift mod Z.
// Purely combinational; the caller registers the result.
module ldpc_circ_rotate #(
  parameter int Z  = 5,
  parameter int SW = 3
) (
  input  logic [Z-1:0]  data,
  input  logic [SW-1:0] shift,
  output logic [Z-1:0]  rotated
);
  logic [SW-1:0]  s_mod;
  logic [2*Z-1:0] wide;

  // Doubling the block turns the rotate into a plain shift and upper slice.
  always_comb begin
    s_mod   = shift % SW'(Z);
    wide    = {data, data} << s_mod;
    rotated = wide[2*Z-1:Z];
  end
endmodule

// File: rtl/ldpc_msg_feeder.sv
// Feeds rotated message blocks of one codeword to the parity accumulator,
// framing each codeword with an accumulator clear and a done handshake.
module ldpc_msg_feeder
  import ldpc_msg_feeder_pkg::*;
#(
  parameter int Z     = Z_DEF,
  parameter int CYCLE = CYCLE_DEF,
  parameter int SW    = SW_DEF,
  parameter logic [CYCLE*SW-1:0] SHIFT_TABLE = SHIFT_TABLE_DEF
) (
  input logic clk,
  input logic rst,
  ldpc_msg_feeder_if.slave bus
);
  localparam int IW = idx_width(CYCLE);
  localparam logic [IW-1:0] LAST_IDX = IW'(CYCLE - 1);

  state_t        state;
  logic [IW-1:0] blk_idx_r;
  logic [Z-1:0]  u_r;
  logic          ce_r;
  logic          acc_clr_r;
  logic          cw_done_r;
  logic          in_ready_r;
  logic [SW-1:0] shift_s;
  logic [Z-1:0]  rot_s;
  logic          hs_s;

  // Shift entry of the block about to be accepted.
  always_comb begin
    shift_s = '0;
    for (int k = 0; k < CYCLE; k++) begin
      shift_s = (blk_idx_r == IW'(k)) ? SHIFT_TABLE[k*SW +: SW] : shift_s;
    end
  end

  ldpc_circ_rotate #(.Z(Z), .SW(SW)) u_rotate (
    .data    (bus.in_data),
    .shift   (shift_s),
    .rotated (rot_s)
  );

  assign hs_s = bus.in_valid & in_ready_r;

  // Codeword FSM; every output is a register.  Leaving reset spends one
  // cycle in CLEAR with acc_clr low so the clear pulse lands after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_CLEAR;
      blk_idx_r  <= '0;
      u_r        <= '0;
      ce_r       <= 1'b0;
      acc_clr_r  <= 1'b0;
      cw_done_r  <= 1'b0;
      in_ready_r <= 1'b0;
    end else begin
      ce_r <= 1'b0;
      u_r  <= '0;
      case (state)
        ST_CLEAR: begin
          if (acc_clr_r) begin
            acc_clr_r  <= 1'b0;
            in_ready_r <= 1'b1;
            state      <= ST_FEED;
          end else begin
            acc_clr_r  <= 1'b1;
          end
        end
        ST_FEED: begin
          if (hs_s) begin
            ce_r <= 1'b1;
            u_r  <= rot_s;
            if (blk_idx_r == LAST_IDX) begin
              blk_idx_r  <= '0;
              in_ready_r <= 1'b0;
              state      <= ST_LAST;
            end else begin
              blk_idx_r  <= blk_idx_r + IW'(1);
            end
          end
        end
        ST_LAST: begin
          cw_done_r <= 1'b1;
          state     <= ST_DONE;
        end
        ST_DONE: begin
          if (bus.done_ack) begin
            cw_done_r <= 1'b0;
            acc_clr_r <= 1'b1;
            state     <= ST_CLEAR;
          end
        end
        default: begin
          blk_idx_r  <= '0;
          acc_clr_r  <= 1'b0;
          cw_done_r  <= 1'b0;
          in_ready_r <= 1'b0;
          state      <= ST_CLEAR;
        end
      endcase
    end
  end

  assign bus.u        = u_r;
  assign bus.ce       = ce_r;
  assign bus.acc_clr  = acc_clr_r;
  assign bus.cw_done  = cw_done_r;
  assign bus.in_ready = in_ready_r;
  assign bus.blk_idx  = blk_idx_r;
endmodule

// File: tb/tb_ldpc_msg_feeder.sv
// Directed bench for ldpc_msg_feeder (Z=5, CYCLE=3, shifts 0,1,2) plus a
// second instance whose shift entries are all 7.
module tb_ldpc_msg_feeder;
  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] in_data;
  logic       in_valid;
  logic       done_ack;
  int         n_tests = 0;
  int         n_fail  = 0;
  logic [4:0] par;

  always #5 clk = ~clk;

  ldpc_msg_feeder_if #(.Z(5), .IW(2)) bus  ();
  ldpc_msg_feeder_if #(.Z(5), .IW(2)) bus7 ();

  assign bus.in_data   = in_data;
  assign bus.in_valid  = in_valid;
  assign bus.done_ack  = done_ack;
  assign bus7.in_data  = in_data;
  assign bus7.in_valid = in_valid;
  assign bus7.done_ack = done_ack;

  ldpc_msg_feeder #(.Z(5), .CYCLE(3), .SW(3), .SHIFT_TABLE(9'b010_001_000)) dut (
    .clk (clk), .rst (rst), .bus (bus.slave)
  );

  ldpc_msg_feeder #(.Z(5), .CYCLE(3), .SW(3), .SHIFT_TABLE(9'b111_111_111)) dut7 (
    .clk (clk), .rst (rst), .bus (bus7.slave)
  );

  // {acc_clr, in_ready, ce, cw_done}
  wire [3:0] obs = {bus.acc_clr, bus.in_ready, bus.ce, bus.cw_done};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; in_data = 5'b11111; done_ack = 1'b0;
    repeat (3) step();
    n_tests++; if (obs !== 4'b0000) begin n_fail++; $display("FAIL reset_flags: got %b want 0000", obs); end
    n_tests++; if (bus.u !== 5'b00000) begin n_fail++; $display("FAIL reset_u: got %b want 00000", bus.u); end
    n_tests++; if (bus.blk_idx !== 2'd0) begin n_fail++; $display("FAIL reset_idx: got %0d want 0", bus.blk_idx); end
    rst = 1'b0;
    step();
    n_tests++; if (obs !== 4'b1000) begin n_fail++; $display("FAIL clear_cycle: got %b want 1000", obs); end
    step();
    n_tests++; if (obs !== 4'b0100) begin n_fail++; $display("FAIL feed_entry: got %b want 0100", obs); end
    n_tests++; if (bus.blk_idx !== 2'd0) begin n_fail++; $display("FAIL feed_idx: got %0d want 0", bus.blk_idx); end
    in_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [4:0] din [3] = '{5'b00001, 5'b00001, 5'b10000};
    logic [4:0] uexp[3] = '{5'b00001, 5'b00010, 5'b00010};
    logic [1:0] iexp[3] = '{2'd1, 2'd2, 2'd0};
    logic [3:0] fexp[3] = '{4'b0110, 4'b0110, 4'b0010};
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_data = din[k];
      step();
      n_tests++; if (obs !== fexp[k]) begin n_fail++; $display("FAIL b2b_flags[%0d]: got %b want %b", k, obs, fexp[k]); end
      n_tests++; if (bus.u !== uexp[k]) begin n_fail++; $display("FAIL b2b_u[%0d]: got %b want %b", k, bus.u, uexp[k]); end
      n_tests++; if (bus.blk_idx !== iexp[k]) begin n_fail++; $display("FAIL b2b_idx[%0d]: got %0d want %0d", k, bus.blk_idx, iexp[k]); end
    end
    in_valid = 1'b0;
    step();
    n_tests++; if (obs !== 4'b0001) begin n_fail++; $display("FAIL b2b_done: got %b want 0001", obs); end
    n_tests++; if (bus.u !== 5'b00000) begin n_fail++; $display("FAIL b2b_u_idle: got %b want 00000", bus.u); end
  endtask

  task automatic test_done_hold();
    done_ack = 1'b0; in_valid = 1'b1; in_data = 5'b10101;
    for (int c = 0; c < 10; c++) begin
      step();
      n_tests++; if (obs !== 4'b0001) begin n_fail++; $display("FAIL done_hold[%0d]: got %b want 0001", c, obs); end
    end
    done_ack = 1'b1; in_valid = 1'b0;
    step();
    n_tests++; if (obs !== 4'b1000) begin n_fail++; $display("FAIL ack_clear: got %b want 1000", obs); end
    done_ack = 1'b0;
    step();
    n_tests++; if (obs !== 4'b0100 || bus.blk_idx !== 2'd0) begin n_fail++; $display("FAIL ack_feed: got %b/%0d want 0100/0", obs, bus.blk_idx); end
  endtask

  task automatic test_gaps();
    logic [4:0] din [3] = '{5'b00001, 5'b00001, 5'b10000};
    logic [4:0] uexp[3] = '{5'b00001, 5'b00010, 5'b00010};
    logic [1:0] iexp[3] = '{2'd1, 2'd2, 2'd0};
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_data = din[k]; done_ack = 1'b0;
      step();
      n_tests++; if (bus.ce !== 1'b1 || bus.u !== uexp[k]) begin n_fail++; $display("FAIL gap_ce[%0d]: got %b/%b want 1/%b", k, bus.ce, bus.u, uexp[k]); end
      if (k < 2) begin
        in_valid = 1'b0; done_ack = 1'b1; in_data = 5'b11111;
        for (int g = 0; g < 2; g++) begin
          step();
          n_tests++; if (obs !== 4'b0100 || bus.u !== 5'b00000) begin n_fail++; $display("FAIL gap_idle[%0d.%0d]: got %b/%b want 0100/00000", k, g, obs, bus.u); end
          n_tests++; if (bus.blk_idx !== iexp[k]) begin n_fail++; $display("FAIL gap_idx[%0d.%0d]: got %0d want %0d", k, g, bus.blk_idx, iexp[k]); end
        end
      end
    end
    in_valid = 1'b0; done_ack = 1'b0;
    step();
    n_tests++; if (obs !== 4'b0001) begin n_fail++; $display("FAIL gap_done: got %b want 0001", obs); end
    done_ack = 1'b1;
    step();
    done_ack = 1'b0;
    step();
    n_tests++; if (obs !== 4'b0100) begin n_fail++; $display("FAIL gap_refeed: got %b want 0100", obs); end
  endtask

  task automatic test_reset_midcw();
    logic [4:0] din[3] = '{5'b00001, 5'b00001, 5'b10000};
    in_valid = 1'b1; in_data = 5'b00001;
    step();
    n_tests++; if (bus.blk_idx !== 2'd1) begin n_fail++; $display("FAIL mid_idx: got %0d want 1", bus.blk_idx); end
    rst = 1'b1; in_valid = 1'b0;
    step();
    n_tests++; if (obs !== 4'b0000 || bus.u !== 5'b00000 || bus.blk_idx !== 2'd0) begin n_fail++; $display("FAIL mid_reset: got %b/%b/%0d want 0000/00000/0", obs, bus.u, bus.blk_idx); end
    rst = 1'b0;
    step();
    n_tests++; if (obs !== 4'b1000) begin n_fail++; $display("FAIL mid_clear: got %b want 1000", obs); end
    par = 5'b00000;
    step();
    n_tests++; if (obs !== 4'b0100 || bus.blk_idx !== 2'd0) begin n_fail++; $display("FAIL mid_restart: got %b/%0d want 0100/0", obs, bus.blk_idx); end
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_data = din[k];
      step();
      if (bus.ce === 1'b1) par = par ^ bus.u;
    end
    in_valid = 1'b0;
    step();
    n_tests++; if (par !== 5'b00001) begin n_fail++; $display("FAIL mid_parity: got %b want 00001", par); end
    n_tests++; if (obs !== 4'b0001) begin n_fail++; $display("FAIL mid_done: got %b want 0001", obs); end
    done_ack = 1'b1;
    step();
    done_ack = 1'b0;
    step();
  endtask

  task automatic test_rotate_mod();
    logic [4:0] din [3] = '{5'b00001, 5'b01000, 5'b10000};
    logic [4:0] uexp[3] = '{5'b00100, 5'b00001, 5'b00010};
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_data = din[k];
      step();
      n_tests++; if (bus7.ce !== 1'b1 || bus7.u !== uexp[k]) begin n_fail++; $display("FAIL rot7[%0d]: got %b/%b want 1/%b", k, bus7.ce, bus7.u, uexp[k]); end
    end
    in_valid = 1'b0;
    step();
    n_tests++; if (bus7.cw_done !== 1'b1) begin n_fail++; $display("FAIL rot7_done: got %b want 1", bus7.cw_done); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_done_hold();
    test_gaps();
    test_reset_midcw();
    test_rotate_mod();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/ldpc_msg_feeder.md
LDPC_MSG_FEEDER -- requirements
Module: ldpc_msg_feeder

Interface
REQ-001 Parameter Z, default 5, circulant size and message block width in bits.
REQ-002 Parameter CYCLE, default 3, number of message blocks per codeword.
REQ-003 Parameter SW, default 3, width of one shift entry; SW SHALL satisfy 2^SW >= Z.
REQ-004 Parameter SHIFT_TABLE, default {3'd2,3'd1,3'd0}, CYCLE*SW bits; entry k occupies bits [k*SW +: SW].
REQ-005 clk  in  1  single clock; all logic on the rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 in_data  in  Z  message block.
REQ-008 in_valid  in  1  in_data is valid.
REQ-009 in_ready  out  1  block accepts in_data this cycle.
REQ-010 u  out  Z  rotated block to the parity accumulator.
REQ-011 ce  out  1  accumulate-enable to the parity accumulator.
REQ-012 acc_clr  out  1  one-cycle clear pulse to the parity accumulator.
REQ-013 blk_idx  out  clog2(CYCLE)  index of the next block to be accepted.
REQ-014 cw_done  out  1  parity of the current codeword is final.
REQ-015 done_ack  in  1  consumer has taken the parity; releases cw_done.

Function
REQ-016 States: CLEAR, FEED, LAST, DONE; encoding is an implementation choice.
REQ-017 CLEAR: acc_clr=1, in_ready=0; always goes to FEED on the next cycle.
REQ-018 FEED: in_ready=1; a handshake is in_valid&in_ready.
REQ-019 FEED: on a handshake with blk_idx<CYCLE-1, blk_idx increments; on a handshake with blk_idx==CYCLE-1, blk_idx returns to 0 and the next state is LAST.
REQ-020 Rotation: for each accepted block with index k and s = SHIFT_TABLE[k] mod Z, u[(i+s) mod Z] = in_data[i] for all i.
REQ-021 u and ce are registered: the cycle after a handshake, ce=1 and u holds the rotated block; in any other cycle, ce=0 and u=0.
REQ-022 Back-to-back handshakes produce ce=1 on consecutive cycles with no bubble.
REQ-023 LAST: in_ready=0; carries the ce of the final block; always goes to DONE on the next cycle.
REQ-024 DONE: cw_done=1, in_ready=0, ce=0; stays in DONE until done_ack=1, then goes to CLEAR.
REQ-025 done_ack outside DONE is ignored; in_valid outside FEED is ignored and no data is consumed.
REQ-026 In FEED, in_valid=0 holds blk_idx and the state.
REQ-027 acc_clr, ce and cw_done are never asserted in the same cycle.

Reset
REQ-028 While rst=1: state=CLEAR, blk_idx=0, u=0, ce=0, cw_done=0, in_ready=0.
REQ-029 While rst=1, acc_clr=0; the first cycle after reset is released is the CLEAR cycle and has acc_clr=1.
REQ-030 rst asserted mid-codeword discards the partial codeword; the next accepted block is index 0.

Structure
REQ-031 Z, CYCLE, SW and the default shift table belong in the shared LDPC parameter include file, ldpc_params.vh.
REQ-032 The rotation is a separate combinational sub-module, ldpc_circ_rotate, with parameters Z and SW, inputs data and shift, and output rotated data.
REQ-033 The output of ldpc_feeder connects directly to the parity accumulator's u/ce inputs; acc_clr is ORed with system rst at the accumulator's reset input.

Verification (Z=5, CYCLE=3, SHIFT_TABLE entries 0,1,2)
REQ-034 Reset release, in_valid=1 → one acc_clr cycle, then in_ready=1 with blk_idx=0.
REQ-035 Blocks 00001, 00001, 10000 back-to-back → u=00001, 00010, 00010 with ce=1 on 3 consecutive cycles, then cw_done=1 one cycle after the last ce.
REQ-036 in_valid gaps between blocks → ce pulses only after each handshake; blk_idx holds during gaps.
REQ-037 done_ack held 0 for 10 cycles → cw_done stays 1 and in_ready stays 0; done_ack=1 → CLEAR, then FEED.
REQ-038 rst asserted after block 1 → all outputs reset; a new codeword starts at blk_idx=0 and parity equals the clean-run result.
REQ-039 SHIFT_TABLE entry 7 with Z=5 → rotation by 2.
